// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: sink for the GPU pixel stream. Clears the framebuffer at
// frame start, queues incoming pixels in a FIFO and converts them into
// linear-address framebuffer writes, then pulses frame_done at frame end.
module fb_pixel_writer #(
    parameter int         FIFO_DEPTH  = 16,
    parameter int         ADDR_W      = 19,
    parameter logic [7:0] CLEAR_COLOR = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic [10:0]       width,
    input  logic [10:0]       height,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [7:0]        pix_color,
    input  logic [10:0]       pix_x,
    input  logic [10:0]       pix_y,
    input  logic              pix_draw,
    output logic              fb_wr_en,
    input  logic              fb_wr_ready,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [7:0]        fb_wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       oob_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    // frame parameters and end-of-stream tracking
    logic [10:0] r_width;
    logic [10:0] r_height;
    logic [21:0] r_total;
    logic        r_fe_prev;
    logic        r_end_seen;
    logic [21:0] r_clr_cnt;

    // pixel FIFO
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;

    // stage 1
    logic        r_s1_v;
    logic [7:0]  r_s1_color;
    logic [10:0] r_s1_x;
    logic [10:0] r_s1_y;
    logic        r_s1_draw;
    logic [21:0] r_s1_prod;

    // stage 2 / write port
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [15:0]       r_oob;

    logic          w_fe_rise;
    logic          w_out_hold;
    logic          w_fifo_empty;
    logic          w_fifo_full;
    logic          w_push;
    logic          w_pop;
    logic          w_pipe_run;
    logic          w_clr_left;
    logic          w_start;
    logic          w_s1_inb;
    logic [21:0]   w_area;
    logic [EW-1:0] w_rd;

    assign w_area       = {11'd0, width} * {11'd0, height};
    assign w_fe_rise    = frame_end & ~r_fe_prev;
    assign w_out_hold   = r_wr_en & ~fb_wr_ready;
    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_pipe_run   = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_push       = pix_valid & pix_ready;
    assign w_pop        = w_pipe_run & ~w_fifo_empty & ~w_out_hold;
    assign w_clr_left   = (r_clr_cnt != r_total);
    assign w_start      = (r_state == ST_IDLE) & frame_start;
    assign w_s1_inb     = (r_s1_x < r_width) && (r_s1_y < r_height);
    assign w_rd         = r_mem[r_rp];

    assign fb_wr_en   = r_wr_en;
    assign fb_wr_addr = r_wr_addr;
    assign fb_wr_data = r_wr_data;
    assign oob_count  = r_oob;

    // state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    // next-state and state-decoded outputs
    always_comb begin
        w_state_nx = r_state;
        pix_ready  = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (frame_start) w_state_nx = (w_area == '0) ? ST_RUN : ST_CLEAR;
            end
            ST_CLEAR: begin
                pix_ready = ~w_fifo_full;
                if (r_wr_en && fb_wr_ready && !w_clr_left) w_state_nx = ST_RUN;
            end
            ST_RUN: begin
                pix_ready = ~w_fifo_full;
                if (r_end_seen) w_state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_fifo_empty && !r_s1_v && !r_wr_en) w_state_nx = ST_DONE;
            end
            ST_DONE: begin
                frame_done = 1'b1;
                w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // latch frame geometry at start; track frame_end rising edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_width    <= '0;
            r_height   <= '0;
            r_total    <= '0;
            r_fe_prev  <= 1'b1;
            r_end_seen <= 1'b0;
        end else begin
            r_fe_prev <= frame_end;
            if (w_start) begin
                r_width    <= width;
                r_height   <= height;
                r_total    <= w_area;
                r_end_seen <= 1'b0;
            end else if (w_fe_rise && (r_state == ST_CLEAR || r_state == ST_RUN)) begin
                r_end_seen <= 1'b1;
            end
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= {pix_color, pix_x, pix_y, pix_draw};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // stage 1: register popped pixel and its row offset y*width
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_v     <= 1'b0;
            r_s1_color <= '0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_draw  <= 1'b0;
            r_s1_prod  <= '0;
        end else if (!w_out_hold) begin
            r_s1_v <= w_pop;
            if (w_pop) begin
                r_s1_color <= w_rd[30:23];
                r_s1_x     <= w_rd[22:12];
                r_s1_y     <= w_rd[11:1];
                r_s1_draw  <= w_rd[0];
                r_s1_prod  <= {11'd0, w_rd[11:1]} * {11'd0, r_width};
            end
        end
    end

    // stage 2 / write port: clear writes in CLEAR, pixel writes in RUN/DRAIN;
    // the port registers only advance when no write is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_clr_cnt <= '0;
            r_oob     <= '0;
        end else begin
            if (w_start) begin
                r_clr_cnt <= '0;
                r_oob     <= '0;
            end
            if (!w_out_hold) begin
                r_wr_en <= 1'b0;
                if (r_state == ST_CLEAR) begin
                    if (w_clr_left) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= ADDR_W'(r_clr_cnt);
                        r_wr_data <= CLEAR_COLOR;
                        r_clr_cnt <= r_clr_cnt + 22'd1;
                    end
                end else if (w_pipe_run && r_s1_v && r_s1_draw) begin
                    if (w_s1_inb) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= ADDR_W'(r_s1_prod + {11'd0, r_s1_x});
                        r_wr_data <= r_s1_color;
                    end else if (r_oob != 16'hFFFF) begin
                        r_oob <= r_oob + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb_fb_pixel_writer: randomized and directed frames checked against a
// queue-based model of the expected framebuffer write stream.
module tb_fb_pixel_writer;

    localparam int ADDR_W = 19;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              frame_start = 1'b0;
    logic              frame_end = 1'b0;
    logic [10:0]       width = '0;
    logic [10:0]       height = '0;
    logic              pix_valid = 1'b0;
    logic              pix_ready;
    logic [7:0]        pix_color = '0;
    logic [10:0]       pix_x = '0;
    logic [10:0]       pix_y = '0;
    logic              pix_draw = 1'b0;
    logic              fb_wr_en;
    logic              fb_wr_ready = 1'b1;
    logic [ADDR_W-1:0] fb_wr_addr;
    logic [7:0]        fb_wr_data;
    logic              busy;
    logic              frame_done;
    logic [15:0]       oob_count;

    fb_pixel_writer #(.FIFO_DEPTH(16), .ADDR_W(ADDR_W), .CLEAR_COLOR(8'h00)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
        .width(width), .height(height), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_color(pix_color), .pix_x(pix_x), .pix_y(pix_y), .pix_draw(pix_draw),
        .fb_wr_en(fb_wr_en), .fb_wr_ready(fb_wr_ready), .fb_wr_addr(fb_wr_addr),
        .fb_wr_data(fb_wr_data), .busy(busy), .frame_done(frame_done), .oob_count(oob_count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model: expected write stream and out-of-bounds count
    logic [ADDR_W+7:0] exp_q[$];
    int m_w = 0, m_h = 0, m_oob = 0;
    int n_acc = 0, n_wr = 0, n_done = 0;
    bit stall = 0, rnd_rdy = 0;
    bit held = 0;
    logic [ADDR_W-1:0] h_addr;
    logic [7:0]        h_data;

    always @(posedge clk) begin
        #1;
        fb_wr_ready = stall ? 1'b0 : (rnd_rdy ? ($urandom_range(3) != 0) : 1'b1);
    end

    always @(negedge clk) begin
        logic [ADDR_W+7:0] e;
        if (held) begin
            check("hold_en", fb_wr_en, 1);
            check("hold_addr", fb_wr_addr, h_addr);
            check("hold_data", fb_wr_data, h_data);
        end
        held = 0;
        if (!reset && fb_wr_en && !fb_wr_ready) begin
            held = 1;
            h_addr = fb_wr_addr;
            h_data = fb_wr_data;
        end
        if (!reset && fb_wr_en && fb_wr_ready) begin
            n_wr++;
            check("wr_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_addr", fb_wr_addr, e[ADDR_W+7:8]);
                check("wr_data", fb_wr_data, e[7:0]);
            end
        end
        if (!reset && pix_valid && pix_ready) begin
            n_acc++;
            if (pix_draw) begin
                if (int'(pix_x) >= m_w || int'(pix_y) >= m_h)
                    m_oob = (m_oob < 65535) ? m_oob + 1 : m_oob;
                else
                    exp_q.push_back({ADDR_W'(int'(pix_y) * m_w + int'(pix_x)), pix_color});
            end
        end
        if (frame_done) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int w, input int h);
        int g = 0;
        while (busy && g < 10000) begin tick(); g++; end
        check("idle_before_start", busy, 0);
        width = 11'(w); height = 11'(h); frame_start = 1'b1;
        m_w = w; m_h = h; m_oob = 0;
        for (int i = 0; i < w * h; i++) exp_q.push_back({ADDR_W'(i), 8'h00});
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_pix(input int x, input int y, input logic [7:0] c, input logic d);
        int g = 0;
        bit acc = 0;
        pix_valid = 1'b1; pix_x = 11'(x); pix_y = 11'(y); pix_color = c; pix_draw = d;
        while (!acc && g < 20000) begin
            @(negedge clk);
            acc = pix_ready;
            tick();
            g++;
        end
        pix_valid = 1'b0;
        check("pix_accept", acc, 1);
    endtask

    task automatic end_frame();
        int g = 0;
        bit seen = 0;
        frame_end = 1'b1;
        while (!seen && g < 20000) begin
            @(negedge clk);
            seen = frame_done;
            if (!seen) begin @(posedge clk); g++; end
        end
        check("frame_done_seen", seen, 1);
        @(negedge clk);
        check("done_one_pulse", frame_done, 0);
        check("busy_after_done", busy, 0);
        check("exp_q_empty", exp_q.size(), 0);
        check("oob_count", oob_count, m_oob);
        tick();
        frame_end = 1'b0;
    endtask

    initial begin
        int g, acc0, d0, w, h, np;

        // 1: reset held 3 cycles
        repeat (3) tick();
        check("rst_wr_en", fb_wr_en, 0);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_addr", fb_wr_addr, 0);
        check("rst_data", fb_wr_data, 0);
        check("rst_oob", oob_count, 0);
        reset = 1'b0;
        repeat (5) tick();
        check("no_done_after_rst", n_done, 0);

        // 2: 4x2 frame, one pixel at (1,1)
        d0 = n_wr;
        start_frame(4, 2);
        send_pix(1, 1, 8'hAB, 1'b1);
        end_frame();
        check("t2_write_count", n_wr - d0, 9);
        check("t2_done_count", n_done, 1);

        // 3: out-of-bounds and non-drawn pixels
        d0 = n_wr;
        start_frame(4, 2);
        send_pix(4, 0, 8'h11, 1'b1);
        send_pix(0, 0, 8'h22, 1'b0);
        end_frame();
        check("t3_oob", oob_count, 1);
        check("t3_write_count", n_wr - d0, 8);

        // 4: write port stalled for 40 cycles while 20 pixels are offered
        start_frame(8, 4);
        g = 0;
        while (exp_q.size() != 0 && g < 1000) begin tick(); g++; end
        repeat (3) tick();
        stall = 1;
        tick();
        acc0 = n_acc;
        fork
            begin
                for (int i = 0; i < 20; i++) send_pix(i % 8, (i / 8) % 4, 8'($urandom), 1'b1);
            end
            begin
                repeat (38) tick();
                check("stall_accepted", n_acc - acc0, 18);
                check("stall_pix_ready", pix_ready, 0);
                tick();
                stall = 0;
            end
        join
        end_frame();

        // 5: 64x64 frame, pixels and frame_end arrive during clear
        d0 = n_wr;
        start_frame(64, 64);
        send_pix(3, 2, 8'h5A, 1'b1);
        send_pix(63, 63, 8'hC3, 1'b1);
        send_pix(0, 1, 8'h7E, 1'b1);
        end_frame();
        check("t5_write_count", n_wr - d0, 4099);

        // 6: reset during clear
        start_frame(16, 16);
        repeat (20) tick();
        reset = 1'b1;
        tick();
        check("t6_wr_en", fb_wr_en, 0);
        check("t6_busy", busy, 0);
        reset = 1'b0;
        exp_q.delete();
        d0 = n_done;
        repeat (5) tick();
        check("t6_no_done", n_done, d0);
        check("t6_pix_ready", pix_ready, 0);
        start_frame(4, 2);
        send_pix(2, 1, 8'h99, 1'b1);
        end_frame();

        // randomized frames with random write backpressure
        rnd_rdy = 1;
        for (int f = 0; f < 6; f++) begin
            w = (f == 0) ? 0 : $urandom_range(1, 12);
            h = $urandom_range(1, 10);
            start_frame(w, h);
            np = $urandom_range(5, 30);
            for (int p = 0; p < np; p++)
                send_pix($urandom_range(0, w + 2), $urandom_range(0, h + 2),
                         8'($urandom), ($urandom_range(0, 3) != 0));
            end_frame();
        end
        rnd_rdy = 0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
